// File: rtl/sao_stat_accum.sv
// SAO edge-offset statistics accumulator: per-category diff sums and pixel
// counts over the beats of one CTB, held until the consumer takes them.
module sao_stat_accum #(
  parameter int DIFF_CLIP_BIT = 4,
  parameter int N_PIX         = 4,
  parameter int SUM_W         = 18,
  parameter int CNT_W         = 13
) (
  input  logic                     clk,
  input  logic                     arst_n,
  input  logic                     rst_n,
  input  logic                     en,
  input  logic                     in_vld,
  output logic                     in_rdy,
  input  logic signed [DIFF_CLIP_BIT:0] n_diff [0:N_PIX-1],
  input  logic [2:0]               cat [0:N_PIX-1],
  input  logic [1:0]               cIdx,
  input  logic                     not_end,
  output logic                     out_vld,
  input  logic                     out_rdy,
  output logic signed [SUM_W-1:0]  sum [1:4],
  output logic [CNT_W-1:0]         cnt [1:4],
  output logic [1:0]               out_cIdx
);

  typedef enum logic [1:0] {
    IDLE,
    ACC,
    HOLD
  } state_t;

  state_t state_q, state_d;

  logic                    accept;
  logic signed [SUM_W-1:0] dsum  [1:4];
  logic [2:0]              dcnt  [1:4];
  logic signed [SUM_W-1:0] sum_n [1:4];
  logic [CNT_W:0]          csum  [1:4];
  logic [CNT_W-1:0]        cnt_n [1:4];

  assign in_rdy  = (state_q != HOLD);
  assign out_vld = (state_q == HOLD);
  assign accept  = in_vld & in_rdy & en;

  always_comb begin
    for (int k = 1; k <= 4; k++) begin
      dsum[k] = '0;
      dcnt[k] = '0;
      for (int i = 0; i < N_PIX; i++) begin
        if (cat[i] == 3'(k)) begin
          dsum[k] = dsum[k] +
            {{(SUM_W-DIFF_CLIP_BIT-1){n_diff[i][DIFF_CLIP_BIT]}},
             n_diff[i]};
          dcnt[k] = dcnt[k] + 3'd1;
        end
      end
    end
  end

  // First beat of a CTB starts from zero instead of the previous result
  always_comb begin
    for (int k = 1; k <= 4; k++) begin
      sum_n[k] = ((state_q == IDLE) ? '0 : sum[k]) + dsum[k];
      csum[k]  = {1'b0, ((state_q == IDLE) ? '0 : cnt[k])} +
                 {{(CNT_W-2){1'b0}}, dcnt[k]};
      cnt_n[k] = csum[k][CNT_W] ? '1 : csum[k][CNT_W-1:0];
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (accept) state_d = not_end ? ACC : HOLD;
      ACC:  if (accept && !not_end) state_d = HOLD;
      HOLD: if (out_rdy) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      state_q  <= IDLE;
      out_cIdx <= '0;
      for (int k = 1; k <= 4; k++) begin
        sum[k] <= '0;
        cnt[k] <= '0;
      end
    end else if (!rst_n) begin
      state_q  <= IDLE;
      out_cIdx <= '0;
      for (int k = 1; k <= 4; k++) begin
        sum[k] <= '0;
        cnt[k] <= '0;
      end
    end else begin
      state_q <= state_d;
      if (accept) begin
        if (state_q == IDLE) out_cIdx <= cIdx;
        for (int k = 1; k <= 4; k++) begin
          sum[k] <= sum_n[k];
          cnt[k] <= cnt_n[k];
        end
      end
    end
  end

endmodule

// File: tb/tb_sao_stat_accum.sv
// Directed self-checking bench for sao_stat_accum.
module tb_sao_stat_accum;

  logic              clk = 1'b0;
  logic              arst_n, rst_n, en, in_vld, in_rdy;
  logic signed [4:0] n_diff [0:3];
  logic [2:0]        cat [0:3];
  logic [1:0]        cIdx, out_cIdx;
  logic              not_end, out_vld, out_rdy;
  logic signed [17:0] sum [1:4];
  logic [12:0]       cnt [1:4];

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  sao_stat_accum dut (
    .clk(clk), .arst_n(arst_n), .rst_n(rst_n), .en(en),
    .in_vld(in_vld), .in_rdy(in_rdy), .n_diff(n_diff), .cat(cat),
    .cIdx(cIdx), .not_end(not_end), .out_vld(out_vld),
    .out_rdy(out_rdy), .sum(sum), .cnt(cnt), .out_cIdx(out_cIdx)
  );

  task automatic set_beat(input int d0, d1, d2, d3,
                          input int c0, c1, c2, c3,
                          input int ci, input bit ne);
    n_diff[0] = 5'(d0); n_diff[1] = 5'(d1);
    n_diff[2] = 5'(d2); n_diff[3] = 5'(d3);
    cat[0] = 3'(c0); cat[1] = 3'(c1);
    cat[2] = 3'(c2); cat[3] = 3'(c3);
    cIdx = 2'(ci);
    not_end = ne;
  endtask

  task automatic beat(input int d0, d1, d2, d3,
                      input int c0, c1, c2, c3,
                      input int ci, input bit ne);
    set_beat(d0, d1, d2, d3, c0, c1, c2, c3, ci, ne);
    in_vld = 1'b1;
    @(posedge clk); #1;
    in_vld = 1'b0;
  endtask

  task automatic consume();
    out_rdy = 1'b1;
    @(posedge clk); #1;
    out_rdy = 1'b0;
  endtask

  task automatic test_reset();
    arst_n = 1'b0; rst_n = 1'b1; en = 1'b1;
    in_vld = 1'b0; out_rdy = 1'b0;
    set_beat(0, 0, 0, 0, 0, 0, 0, 0, 0, 1'b1);
    #2;
    checks++;
    if (out_vld !== 1'b0 || in_rdy !== 1'b1 || out_cIdx !== 2'd0) begin
      failures++;
      $display("FAIL reset_ctl vld=%b rdy=%b cidx=%0d exp 0 1 0",
               out_vld, in_rdy, out_cIdx);
    end
    for (int k = 1; k <= 4; k++) begin
      checks++;
      if (sum[k] !== 18'sd0 || cnt[k] !== 13'd0) begin
        failures++;
        $display("FAIL reset_acc k=%0d sum=%0d cnt=%0d exp 0 0",
                 k, sum[k], cnt[k]);
      end
    end
    #10 arst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_basic();
    int es[1:4] = '{-1, 3, 0, 20};
    int ec[1:4] = '{2, 1, 0, 4};
    beat(1, -2, 3, -4, 1, 1, 2, 0, 1, 1'b1);
    checks++;
    if (out_vld !== 1'b0 || sum[1] !== -18'sd1 || cnt[2] !== 13'd1) begin
      failures++;
      $display("FAIL basic_live vld=%b sum1=%0d cnt2=%0d exp 0 -1 1",
               out_vld, sum[1], cnt[2]);
    end
    beat(5, 5, 5, 5, 4, 4, 4, 4, 3, 1'b0);
    checks++;
    if (out_vld !== 1'b1 || in_rdy !== 1'b0 || out_cIdx !== 2'd1) begin
      failures++;
      $display("FAIL basic_ctl vld=%b rdy=%b cidx=%0d exp 1 0 1",
               out_vld, in_rdy, out_cIdx);
    end
    for (int k = 1; k <= 4; k++) begin
      checks++;
      if (sum[k] !== 18'(es[k]) || cnt[k] !== 13'(ec[k])) begin
        failures++;
        $display("FAIL basic_acc k=%0d sum=%0d cnt=%0d exp %0d %0d",
                 k, sum[k], cnt[k], es[k], ec[k]);
      end
    end
  endtask

  task automatic test_hold();
    set_beat(7, 7, 7, 7, 4, 4, 4, 4, 2, 1'b0);
    in_vld = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(posedge clk); #1;
      checks++;
      if (out_vld !== 1'b1 || in_rdy !== 1'b0 ||
          sum[4] !== 18'sd20 || cnt[4] !== 13'd4 || out_cIdx !== 2'd1) begin
        failures++;
        $display("FAIL hold c=%0d vld=%b rdy=%b sum4=%0d cnt4=%0d exp 1 0 20 4",
                 c, out_vld, in_rdy, sum[4], cnt[4]);
      end
    end
    in_vld = 1'b0;
    consume();
    checks++;
    if (out_vld !== 1'b0 || in_rdy !== 1'b1) begin
      failures++;
      $display("FAIL hold_release vld=%b rdy=%b exp 0 1", out_vld, in_rdy);
    end
  endtask

  task automatic test_wide_sum();
    for (int b = 0; b < 1024; b++)
      beat(-15, -15, -15, -15, 3, 3, 3, 3, 0, b != 1023);
    checks++;
    if (out_vld !== 1'b1 || cnt[3] !== 13'd4096 || sum[3] !== -18'sd61440) begin
      failures++;
      $display("FAIL wide vld=%b cnt3=%0d sum3=%0d exp 1 4096 -61440",
               out_vld, cnt[3], sum[3]);
    end
    checks++;
    if (cnt[1] !== 13'd0 || sum[4] !== 18'sd0) begin
      failures++;
      $display("FAIL wide_other cnt1=%0d sum4=%0d exp 0 0", cnt[1], sum[4]);
    end
    consume();
  endtask

  task automatic test_saturate();
    for (int b = 0; b < 3000; b++) begin
      beat(1, 1, 1, 1, 1, 1, 1, 1, 0, b != 2999);
      if (b == 2046) begin
        checks++;
        if (cnt[1] !== 13'd8188) begin
          failures++;
          $display("FAIL sat_pre cnt1=%0d exp 8188", cnt[1]);
        end
      end
      if (b == 2047) begin
        checks++;
        if (cnt[1] !== 13'd8191) begin
          failures++;
          $display("FAIL sat_edge cnt1=%0d exp 8191", cnt[1]);
        end
      end
    end
    checks++;
    if (out_vld !== 1'b1 || cnt[1] !== 13'd8191 || sum[1] !== 18'sd12000) begin
      failures++;
      $display("FAIL sat_final vld=%b cnt1=%0d sum1=%0d exp 1 8191 12000",
               out_vld, cnt[1], sum[1]);
    end
    consume();
  endtask

  task automatic test_sync_clear();
    for (int b = 0; b < 3; b++)
      beat(1, 1, 1, 1, 1, 1, 1, 1, 3, 1'b1);
    set_beat(2, 2, 2, 2, 1, 1, 1, 1, 3, 1'b0);
    in_vld = 1'b1; rst_n = 1'b0;
    @(posedge clk); #1;
    in_vld = 1'b0; rst_n = 1'b1;
    checks++;
    if (out_vld !== 1'b0 || in_rdy !== 1'b1 || cnt[1] !== 13'd0 ||
        sum[1] !== 18'sd0 || out_cIdx !== 2'd0) begin
      failures++;
      $display("FAIL sclr_mid vld=%b rdy=%b cnt1=%0d sum1=%0d exp 0 1 0 0",
               out_vld, in_rdy, cnt[1], sum[1]);
    end
    beat(1, 1, 1, 1, 2, 2, 2, 2, 1, 1'b0);
    checks++;
    if (out_vld !== 1'b1 || cnt[2] !== 13'd4 || sum[2] !== 18'sd4 ||
        cnt[1] !== 13'd0 || sum[1] !== 18'sd0 || cnt[3] !== 13'd0) begin
      failures++;
      $display("FAIL sclr_after cnt2=%0d sum2=%0d cnt1=%0d exp 4 4 0",
               cnt[2], sum[2], cnt[1]);
    end
    out_rdy = 1'b1; rst_n = 1'b0;
    @(posedge clk); #1;
    out_rdy = 1'b0; rst_n = 1'b1;
    checks++;
    if (out_vld !== 1'b0 || cnt[2] !== 13'd0 || out_cIdx !== 2'd0) begin
      failures++;
      $display("FAIL sclr_hold vld=%b cnt2=%0d cidx=%0d exp 0 0 0",
               out_vld, cnt[2], out_cIdx);
    end
  endtask

  task automatic test_en_cidx();
    set_beat(7, 7, 7, 7, 1, 1, 1, 1, 3, 1'b0);
    en = 1'b0; in_vld = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    checks++;
    if (out_vld !== 1'b0 || in_rdy !== 1'b1) begin
      failures++;
      $display("FAIL en_idle vld=%b rdy=%b exp 0 1", out_vld, in_rdy);
    end
    in_vld = 1'b0; en = 1'b1;
    beat(2, 2, 2, 2, 1, 1, 1, 1, 2, 1'b1);
    checks++;
    if (cnt[1] !== 13'd4 || sum[1] !== 18'sd8) begin
      failures++;
      $display("FAIL en_first cnt1=%0d sum1=%0d exp 4 8", cnt[1], sum[1]);
    end
    set_beat(7, 7, 7, 7, 1, 1, 1, 1, 3, 1'b0);
    en = 1'b0; in_vld = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    in_vld = 1'b0; en = 1'b1;
    checks++;
    if (out_vld !== 1'b0 || cnt[1] !== 13'd4) begin
      failures++;
      $display("FAIL en_acc vld=%b cnt1=%0d exp 0 4", out_vld, cnt[1]);
    end
    beat(3, 3, 3, 3, 1, 1, 1, 1, 1, 1'b0);
    checks++;
    if (out_vld !== 1'b1 || cnt[1] !== 13'd8 || sum[1] !== 18'sd20 ||
        out_cIdx !== 2'd2) begin
      failures++;
      $display("FAIL en_final vld=%b cnt1=%0d sum1=%0d cidx=%0d exp 1 8 20 2",
               out_vld, cnt[1], sum[1], out_cIdx);
    end
    consume();
  endtask

  task automatic test_ignored_cat();
    beat(1, -1, 3, 2, 5, 6, 7, 0, 3, 1'b0);
    checks++;
    if (out_vld !== 1'b1 || out_cIdx !== 2'd3) begin
      failures++;
      $display("FAIL ign_ctl vld=%b cidx=%0d exp 1 3", out_vld, out_cIdx);
    end
    for (int k = 1; k <= 4; k++) begin
      checks++;
      if (sum[k] !== 18'sd0 || cnt[k] !== 13'd0) begin
        failures++;
        $display("FAIL ign_acc k=%0d sum=%0d cnt=%0d exp 0 0",
                 k, sum[k], cnt[k]);
      end
    end
  endtask

  task automatic test_async_hold();
    #2 arst_n = 1'b0;
    #1;
    checks++;
    if (out_vld !== 1'b0 || in_rdy !== 1'b1 || out_cIdx !== 2'd0) begin
      failures++;
      $display("FAIL arst_hold vld=%b rdy=%b cidx=%0d exp 0 1 0",
               out_vld, in_rdy, out_cIdx);
    end
    #2 arst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_hold();
    test_wide_sum();
    test_saturate();
    test_sync_clear();
    test_en_cidx();
    test_ignored_cat();
    test_async_hold();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/sao_stat_accum.md
SAO_STAT_ACCUM -- requirements
Module: sao_stat_accum

Interface
REQ-001 The block SHALL have parameter DIFF_CLIP_BIT, default 4, meaning n_diff is DIFF_CLIP_BIT+1 bits signed.
REQ-002 The block SHALL have parameter N_PIX, default 4, meaning pixels per beat; only 4 is supported.
REQ-003 The block SHALL have parameter SUM_W, default 18, meaning per-category signed sum width.
REQ-004 The block SHALL have parameter CNT_W, default 13, meaning per-category unsigned count width.
REQ-005 The block SHALL have port clk, input, 1 bit: clock, all state on rising edge.
REQ-006 The block SHALL have port arst_n, input, 1 bit: reset, asynchronous, active-low.
REQ-007 The block SHALL have port rst_n, input, 1 bit: synchronous active-low clear.
REQ-008 The block SHALL have port en, input, 1 bit: stage enable (pipeline stall when low).
REQ-009 The block SHALL have port in_vld, input, 1 bit: beat valid.
REQ-010 The block SHALL have port in_rdy, output, 1 bit: beat accepted when in_vld & in_rdy & en.
REQ-011 The block SHALL have port n_diff[0:N_PIX-1], input, DIFF_CLIP_BIT+1 bits signed each: clipped org-minus-deblocked differences.
REQ-012 The block SHALL have port cat[0:N_PIX-1], input, 3 bits each: EO category per pixel (0 = none, 1..4 valid).
REQ-013 The block SHALL have port cIdx, input, 2 bits: colour component of the beat.
REQ-014 The block SHALL have port not_end, input, 1 bit: low marks the last beat of the CTB.
REQ-015 The block SHALL have port out_vld, output, 1 bit: result valid.
REQ-016 The block SHALL have port out_rdy, input, 1 bit: result consumed when out_vld & out_rdy.
REQ-017 The block SHALL have port sum[1:4], output, SUM_W bits signed each: per-category diff sum.
REQ-018 The block SHALL have port cnt[1:4], output, CNT_W bits each: per-category pixel count.
REQ-019 The block SHALL have port out_cIdx, output, 2 bits: cIdx latched on the first beat.

Function
REQ-020 The FSM SHALL have states IDLE, ACC, HOLD; in_rdy = 1 in IDLE and ACC, 0 in HOLD.
REQ-021 On an accepted beat in IDLE, accumulators SHALL load that beat's deltas (no prior residue), out_cIdx SHALL latch cIdx, and the state SHALL go to ACC.
REQ-022 On an accepted beat in ACC, the block SHALL add the deltas to the accumulators; cIdx on non-first beats is ignored.
REQ-023 Per category k in 1..4: the sum delta SHALL be the signed sum of n_diff[i] with cat[i]==k, and the count delta SHALL be the number of such i (0..4).
REQ-024 Pixels with cat 0, 5, 6 or 7 SHALL contribute nothing.
REQ-025 Counts SHALL saturate at 2^CNT_W-1; sums SHALL wrap modulo 2^SUM_W.
REQ-026 An accepted beat with not_end==0, in IDLE or ACC, SHALL be accumulated, and the state SHALL then go to HOLD with out_vld=1 from the next cycle.
REQ-027 A single-beat CTB (IDLE, not_end==0) SHALL go directly to HOLD.
REQ-028 In HOLD, sum, cnt and out_cIdx SHALL stay stable; out_vld & out_rdy SHALL return the state to IDLE, with out_vld=0 the next cycle.
REQ-029 out_rdy SHALL be honoured independent of en; en==0 SHALL freeze only input acceptance.
REQ-030 Beats with in_vld=1 during HOLD SHALL be neither accepted nor counted.
REQ-031 sum and cnt SHALL expose live accumulator values in ACC; consumers SHALL only sample them while out_vld=1.

Reset
REQ-032 arst_n low SHALL immediately force state IDLE and out_vld, sum, cnt, out_cIdx to 0, with in_rdy=1.
REQ-033 rst_n low at a clock edge SHALL have the same effect as arst_n, with priority over en, in_vld and out_rdy, including mid-CTB and in HOLD.

Verification
REQ-034 Scenario: beats {diff 1,-2,3,-4; cat 1,1,2,0}, then {diff 5,5,5,5; cat 4,4,4,4; not_end=0} -> sum={-1,3,0,20}, cnt={2,1,0,4}, out_vld next cycle.
REQ-035 Scenario: hold out_rdy=0 for 5 cycles while driving in_vld=1 -> in_rdy=0, outputs unchanged, no beats absorbed; out_rdy=1 -> IDLE next cycle.
REQ-036 Scenario: 1024 beats, all cat 3, diff -15 -> cnt[3]=4096, sum[3]=-61440, no wrap.
REQ-037 Scenario: 3000 beats, all cat 1 -> cnt[1] saturates at 8191.
REQ-038 Scenario: rst_n pulse after 3 beats, then 1 beat {cat 2,2,2,2; diff 1; not_end=0} -> cnt[2]=4, others 0.
REQ-039 Scenario: en=0 with in_vld=1 for 4 cycles -> no accumulation; first beat cIdx=2 then cIdx=1 -> out_cIdx=2.
